console_poll_gen: RTL

- Synthesisable, parametrised console-side controller poll generator; successor to the fixed SNES latch/clock stimulus.
- Each poll asserts the latch, issues NUM_BITS clock pulses, and captures NUM_CH serial data lines into parallel words with a valid strobe.
- Polls run periodically every FRAME_CYCLES, or on demand.
- Drives the controller-side replay logic on the FPGA, both in bench and on hardware.

---
 rtl/console_poll_gen.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/console_poll_gen.sv
// console_poll_gen: console-side poll generator for SNES/NES style pads.
// Each poll raises the latch and then clocks NUM_BITS bits out of NUM_CH
// serial lines. The captured buttons are presented as one parallel word
// with a single-cycle valid strobe. Polls repeat every FRAME_CYCLES while
// enable is high, or start immediately on poll_now.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | latch low, clock high, waiting for an auto or manual start
// LATCH  | latch high for LATCH_CYCLES
// GAP    | latch low, clock still high for HALF_CYCLES before pulse 0
// LOW    | clock low for HALF_CYCLES; bit k was sampled on entry
// HIGH   | clock high for HALF_CYCLES; then next pulse or DONE
// DONE   | one cycle: publish the word, pulse data_valid, bump count
`timescale 1ns/1ps

module console_poll_gen #(
  parameter int unsigned FRAME_CYCLES = 800000,
  parameter int unsigned LATCH_CYCLES = 576,
  parameter int unsigned HALF_CYCLES  = 288,
  parameter int unsigned NUM_BITS     = 16,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = 20
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       enable,
  input  logic                       poll_now,
  input  logic [NUM_CH-1:0]          data_in,
  output logic                       snes_lat,
  output logic                       snes_clk,
  output logic [NUM_CH*NUM_BITS-1:0] data_out,
  output logic                       data_valid,
  output logic                       busy,
  output logic [15:0]                frame_count
);

  // Cycles from the start edge to the edge that enters DONE.
  localparam int unsigned POLL_LEN = LATCH_CYCLES + HALF_CYCLES + 2 * HALF_CYCLES * NUM_BITS;
  localparam int unsigned BIT_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  // Parameter sanity: a poll (plus its DONE cycle) must fit inside a frame,
  // and every timer load must fit the counter width.
  if (FRAME_CYCLES <= POLL_LEN + 1) begin : g_bad_frame
    $error("console_poll_gen: FRAME_CYCLES must exceed poll length + 1");
  end
  if ((64'(FRAME_CYCLES - 1) >> CNT_W) != 64'd0) begin : g_bad_cnt_w
    $error("console_poll_gen: CNT_W too narrow for FRAME_CYCLES-1");
  end
  if ((64'(LATCH_CYCLES - 1) >> CNT_W) != 64'd0 || (64'(HALF_CYCLES - 1) >> CNT_W) != 64'd0) begin : g_bad_tmr_w
    $error("console_poll_gen: CNT_W too narrow for phase timers");
  end
  if (LATCH_CYCLES < 1 || HALF_CYCLES < 1 || NUM_BITS < 1 || NUM_CH < 1) begin : g_bad_zero
    $error("console_poll_gen: LATCH_CYCLES, HALF_CYCLES, NUM_BITS, NUM_CH must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_GAP   = 3'd2,
    S_LOW   = 3'd3,
    S_HIGH  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                      state_q;
  state_t                      state_nxt;
  logic [CNT_W-1:0]            frame_cnt_q;
  logic [CNT_W-1:0]            tmr_q;
  logic [CNT_W-1:0]            tmr_nxt;
  logic                        tmr_tc;
  logic [BIT_W-1:0]            bit_q;
  logic [BIT_W-1:0]            bit_nxt;
  logic [NUM_CH*NUM_BITS-1:0]  shift_q;
  logic                        start;
  logic                        sample;
  logic                        done_entry;

  // Start request; only honoured in IDLE so a busy poll_now is dropped.
  always_comb begin
    start = (state_q == S_IDLE) && ((enable && (frame_cnt_q == '0)) || poll_now);
  end

  // Next state, phase down-counter and pulse index.
  always_comb begin
    state_nxt  = state_q;
    tmr_tc     = (tmr_q == '0);
    tmr_nxt    = tmr_tc ? tmr_q : (tmr_q - CNT_W'(1));
    bit_nxt    = bit_q;
    sample     = 1'b0;
    done_entry = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LATCH;
          tmr_nxt   = CNT_W'(LATCH_CYCLES - 1);
          bit_nxt   = '0;
        end
      end
      S_LATCH: begin
        if (tmr_tc) begin
          state_nxt = S_GAP;
          tmr_nxt   = CNT_W'(HALF_CYCLES - 1);
        end
      end
      S_GAP: begin
        if (tmr_tc) begin
          state_nxt = S_LOW;
          tmr_nxt   = CNT_W'(HALF_CYCLES - 1);
          sample    = 1'b1;
        end
      end
      S_LOW: begin
        if (tmr_tc) begin
          state_nxt = S_HIGH;
          tmr_nxt   = CNT_W'(HALF_CYCLES - 1);
        end
      end
      S_HIGH: begin
        if (tmr_tc) begin
          if (bit_q == BIT_W'(NUM_BITS - 1)) begin
            state_nxt  = S_DONE;
            done_entry = 1'b1;
          end else begin
            state_nxt = S_LOW;
            tmr_nxt   = CNT_W'(HALF_CYCLES - 1);
            bit_nxt   = bit_q + BIT_W'(1);
            sample    = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Auto-poll cadence. A start edge counts as frame position 0, so the
  // counter reads 1 afterwards and the next auto start lands exactly
  // FRAME_CYCLES edges later whether the poll was automatic or manual.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      frame_cnt_q <= '0;
    end else if (!enable) begin
      frame_cnt_q <= '0;
    end else if (start) begin
      frame_cnt_q <= CNT_W'(1);
    end else if (frame_cnt_q == CNT_W'(FRAME_CYCLES - 1)) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_q + CNT_W'(1);
    end
  end

  // FSM state register with its phase timer and pulse index.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_nxt;
      tmr_q   <= tmr_nxt;
      bit_q   <= bit_nxt;
    end
  end

  // Capture bits as the clock falls; publish the whole word atomically.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shift_q     <= '0;
      data_out    <= '0;
      frame_count <= '0;
    end else begin
      if (start) begin
        shift_q <= '0;
      end
      if (sample) begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
          for (int k = 0; k < int'(NUM_BITS); k++) begin
            if (bit_nxt == BIT_W'(k)) begin
              shift_q[c*NUM_BITS + k] <= ~data_in[c];
            end
          end
        end
      end
      if (done_entry) begin
        data_out    <= shift_q;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Pin outputs registered from the next state so they never glitch.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      snes_lat   <= 1'b0;
      snes_clk   <= 1'b1;
      busy       <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      snes_lat   <= (state_nxt == S_LATCH);
      snes_clk   <= (state_nxt != S_LOW);
      busy       <= (state_nxt != S_IDLE);
      data_valid <= (state_nxt == S_DONE);
    end
  end

endmodule
